// File: rtl/move_controller.sv
// Turn and cursor controller for the tic-tac-toe datapath: moves a cell cursor,
// validates confirms against occupancy, strobes cell writes and tracks turns.
module move_controller #(
  parameter int NUM_CELLS    = 9,
  parameter int SEL_W        = 9,
  parameter int START_PLAYER = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 btn_next,
  input  logic                 btn_prev,
  input  logic                 btn_confirm,
  input  logic                 new_game,
  input  logic [NUM_CELLS-1:0] occ,
  input  logic                 win,
  output logic [SEL_W-1:0]     sel,
  output logic                 wr_en,
  output logic                 mark,
  output logic                 player,
  output logic [3:0]           move_count,
  output logic                 reject,
  output logic                 clear_board,
  output logic                 game_done
);

  localparam int CUR_W = $clog2(NUM_CELLS);
  localparam logic [CUR_W-1:0] LAST_CELL  = CUR_W'(NUM_CELLS - 1);
  localparam logic             START_MARK = 1'(START_PLAYER);
  localparam logic [3:0]       FULL_COUNT = 4'(NUM_CELLS);

  typedef enum logic [2:0] {
    S_SELECT,
    S_CHECK,
    S_WRITE,
    S_REJECT,
    S_SWITCH,
    S_DONE
  } state_t;

  state_t           state_reg;
  logic [CUR_W-1:0] cursor_reg;
  logic [CUR_W-1:0] target_reg;
  logic             player_reg;
  logic             mark_reg;
  logic [3:0]       count_reg;
  logic             wr_en_reg;
  logic             reject_reg;
  logic             clear_reg;
  logic             done_reg;

  logic [3:0]       count_next;
  logic [CUR_W-1:0] sel_idx;

  assign count_next = count_reg + 4'd1;

  // The cursor cannot move while a move is in flight, so target and cursor agree
  // outside SELECT; target is still shown there so the decoder sees the latched cell.
  assign sel_idx = (state_reg == S_CHECK || state_reg == S_WRITE || state_reg == S_REJECT)
                   ? target_reg : cursor_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= S_SELECT;
      cursor_reg <= '0;
      target_reg <= '0;
      player_reg <= START_MARK;
      mark_reg   <= START_MARK;
      count_reg  <= 4'd0;
      wr_en_reg  <= 1'b0;
      reject_reg <= 1'b0;
      clear_reg  <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      wr_en_reg  <= 1'b0;
      reject_reg <= 1'b0;
      clear_reg  <= 1'b0;
      if (new_game) begin
        // Overrides anything in progress, including a write about to be issued.
        state_reg  <= S_SELECT;
        cursor_reg <= '0;
        target_reg <= '0;
        player_reg <= START_MARK;
        count_reg  <= 4'd0;
        done_reg   <= 1'b0;
        clear_reg  <= 1'b1;
      end else begin
        case (state_reg)
          S_SELECT: begin
            if (btn_confirm) begin
              target_reg <= cursor_reg;
              state_reg  <= S_CHECK;
            end else if (btn_next && !btn_prev) begin
              cursor_reg <= (cursor_reg == LAST_CELL) ? '0 : cursor_reg + CUR_W'(1);
            end else if (btn_prev && !btn_next) begin
              cursor_reg <= (cursor_reg == '0) ? LAST_CELL : cursor_reg - CUR_W'(1);
            end
          end
          S_CHECK: begin
            if (occ[target_reg]) begin
              state_reg  <= S_REJECT;
              reject_reg <= 1'b1;
            end else begin
              state_reg <= S_WRITE;
              wr_en_reg <= 1'b1;
              mark_reg  <= player_reg;
            end
          end
          S_WRITE:  state_reg <= S_SWITCH;
          S_REJECT: state_reg <= S_SELECT;
          S_SWITCH: begin
            count_reg  <= count_next;
            player_reg <= ~player_reg;
            if (win || count_next == FULL_COUNT) begin
              state_reg <= S_DONE;
              done_reg  <= 1'b1;
            end else begin
              state_reg <= S_SELECT;
            end
          end
          S_DONE:   state_reg <= S_DONE;
          default:  state_reg <= S_SELECT;
        endcase
      end
    end
  end

  assign sel         = SEL_W'(sel_idx);
  assign wr_en       = wr_en_reg;
  assign mark        = mark_reg;
  assign player      = player_reg;
  assign move_count  = count_reg;
  assign reject      = reject_reg;
  assign clear_board = clear_reg;
  assign game_done   = done_reg;

endmodule

// File: tb/tb_move_controller.sv
// Randomized bench for move_controller against a transaction-level game model
// (cursor arithmetic mod 9, a board array, a move counter and a turn bit).
module tb_move_controller;

  logic       clk = 1'b0;
  logic       rst, btn_next, btn_prev, btn_confirm, new_game, win;
  logic [8:0] occ;
  logic [8:0] sel;
  logic       wr_en, mark, player, reject, clear_board, game_done;
  logic [3:0] move_count;

  move_controller #(.NUM_CELLS(9), .SEL_W(9), .START_PLAYER(0)) dut (
    .clk(clk), .rst(rst), .btn_next(btn_next), .btn_prev(btn_prev),
    .btn_confirm(btn_confirm), .new_game(new_game), .occ(occ), .win(win),
    .sel(sel), .wr_en(wr_en), .mark(mark), .player(player),
    .move_count(move_count), .reject(reject), .clear_board(clear_board),
    .game_done(game_done)
  );

  always #5 clk = ~clk;

  // Reference model of the game
  int m_cursor, m_count;
  bit m_player, m_done;
  bit board [9];
  int n_cmp = 0, n_mis = 0;

  always_comb begin
    occ = '0;
    for (int i = 0; i < 9; i++) occ[i] = board[i];
  end

  task automatic check_val(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_idle(input string tag);
    check_val({tag, ".sel"}, int'(sel), m_cursor);
    check_val({tag, ".player"}, int'(player), int'(m_player));
    check_val({tag, ".count"}, int'(move_count), m_count);
    check_val({tag, ".done"}, int'(game_done), int'(m_done));
    check_val({tag, ".wr_en"}, int'(wr_en), 0);
    check_val({tag, ".reject"}, int'(reject), 0);
  endtask

  task automatic model_reset();
    m_cursor = 0; m_count = 0; m_player = 0; m_done = 0;
    for (int i = 0; i < 9; i++) board[i] = 0;
  endtask

  task automatic step_nav(input bit n, input bit p);
    @(negedge clk); btn_next = n; btn_prev = p;
    @(negedge clk); btn_next = 0; btn_prev = 0;
    if (!m_done) begin
      if (n && !p) m_cursor = (m_cursor + 1) % 9;
      if (p && !n) m_cursor = (m_cursor + 8) % 9;
    end
    $display("nav next=%0d prev=%0d -> cursor %0d", n, p, m_cursor);
    check_idle("nav");
  endtask

  task automatic move_to(input int c);
    for (int k = 0; k < 9 && m_cursor != c; k++) step_nav(1, 0);
  endtask

  // Confirm at the cursor; drv_win drives win during SWITCH, noise pokes
  // buttons and win in cycles where the DUT must ignore them.
  task automatic do_confirm(input bit drv_win, input bit noise);
    @(negedge clk); btn_confirm = 1;
    @(negedge clk); btn_confirm = 0;
    if (m_done) begin
      $display("confirm in DONE ignored");
      btn_next = noise;
      @(negedge clk); btn_next = 0;
      check_idle("done_confirm");
      return;
    end
    check_val("chk.sel", int'(sel), m_cursor);
    check_val("chk.wr_en", int'(wr_en), 0);
    btn_next = noise; btn_prev = ~noise;
    @(negedge clk); btn_next = 0; btn_prev = 0;
    check_val("t2.sel", int'(sel), m_cursor);
    if (board[m_cursor]) begin
      $display("confirm cell %0d occupied -> reject", m_cursor);
      check_val("rej.reject", int'(reject), 1);
      check_val("rej.wr_en", int'(wr_en), 0);
      @(negedge clk);
      check_idle("rej_back");
      return;
    end
    $display("confirm cell %0d free -> write mark %0d win=%0d", m_cursor, m_player, drv_win);
    check_val("wr.wr_en", int'(wr_en), 1);
    check_val("wr.mark", int'(mark), int'(m_player));
    check_val("wr.reject", int'(reject), 0);
    board[m_cursor] = 1;
    win = noise;
    @(negedge clk);
    check_val("sw.wr_en", int'(wr_en), 0);
    win = drv_win;
    @(negedge clk); win = 0;
    m_count++;
    m_player = ~m_player;
    m_done = drv_win || (m_count == 9);
    check_idle("after_move");
  endtask

  task automatic do_new_game();
    @(negedge clk); new_game = 1;
    @(negedge clk); new_game = 0;
    model_reset();
    $display("new_game");
    check_val("ng.clear", int'(clear_board), 1);
    check_idle("ng");
    @(negedge clk);
    check_val("ng.clear_off", int'(clear_board), 0);
  endtask

  initial begin
    rst = 1; btn_next = 0; btn_prev = 0; btn_confirm = 0; new_game = 0; win = 0;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 0;
    check_idle("reset");
    check_val("reset.mark", int'(mark), 0);
    check_val("reset.clear", int'(clear_board), 0);

    // Three steps right, then place X at cell 3
    for (int i = 0; i < 3; i++) step_nav(1, 0);
    do_confirm(0, 0);

    // Wrap in both directions and simultaneous buttons
    do_new_game();
    step_nav(0, 1);
    step_nav(1, 0);
    step_nav(1, 1);

    // Externally occupied cell 4
    board[4] = 1;
    move_to(4);
    do_confirm(0, 1);

    // Win on the fifth move, then buttons are ignored
    do_new_game();
    for (int c = 0; c < 5; c++) begin
      move_to(c);
      do_confirm(c == 4, 1);
    end
    check_val("win.done", int'(game_done), 1);
    check_val("win.count", int'(move_count), 5);
    do_confirm(0, 1);
    step_nav(1, 0);

    // Full board
    do_new_game();
    for (int c = 0; c < 9; c++) begin
      move_to(c);
      do_confirm(0, c[0]);
    end
    check_val("full.done", int'(game_done), 1);
    check_val("full.count", int'(move_count), 9);
    do_new_game();

    // Reset during WRITE
    move_to(2);
    @(negedge clk); btn_confirm = 1;
    @(negedge clk); btn_confirm = 0;
    @(negedge clk);
    check_val("rstw.wr_en_pre", int'(wr_en), 1);
    rst = 1;
    @(negedge clk); rst = 0;
    model_reset();
    $display("reset during WRITE");
    check_idle("rstw");
    check_val("rstw.mark", int'(mark), 0);
    check_val("rstw.clear", int'(clear_board), 0);

    // new_game during CHECK cancels the write
    move_to(5);
    @(negedge clk); btn_confirm = 1;
    @(negedge clk); btn_confirm = 0; new_game = 1;
    @(negedge clk); new_game = 0;
    model_reset();
    $display("new_game during CHECK");
    check_val("ngc.clear", int'(clear_board), 1);
    check_idle("ngc");
    @(negedge clk);
    check_idle("ngc2");

    // Random play
    for (int it = 0; it < 400; it++) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (m_done && $urandom_range(0, 2) == 0) r = 9;
      case (r)
        0, 1, 2: step_nav(1, 0);
        3, 4:    step_nav(0, 1);
        5:       step_nav(1, 1);
        6, 7, 8: do_confirm(m_count >= 4 && $urandom_range(0, 4) == 0, 1'($urandom_range(0, 1)));
        default: if (m_done || $urandom_range(0, 3) == 0) do_new_game(); else step_nav(1, 0);
      endcase
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/move_controller.md
Name: move_controller

Overview:
- Turn and cursor controller for the tic-tac-toe datapath. Sits directly upstream of the 9-way cell decoder.
- Converts debounced button pulses into a binary cell index `sel` (0..8), which the decoder turns into one-hot cell enables.
- Validates each move against board occupancy and issues a one-cycle write strobe with the current player's mark.
- Alternates players, counts moves and stops on win or full board.

Parameters:
- NUM_CELLS, 9, number of board cells; the index range is 0..NUM_CELLS-1.
- SEL_W, 9, width of `sel`, matching the decoder's select input.
- START_PLAYER, 0, player that moves first after reset or new game (0 = X, 1 = O).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- btn_next  input  1  single-cycle pulse: cursor +1.
- btn_prev  input  1  single-cycle pulse: cursor -1.
- btn_confirm  input  1  single-cycle pulse: place mark at cursor.
- new_game  input  1  single-cycle pulse: restart game.
- occ  input  NUM_CELLS  occupancy from cell registers; bit i = cell i taken.
- win  input  1  win detector output, valid the cycle after a write.
- sel  output  SEL_W  binary cell index to decoder; upper bits always 0.
- wr_en  output  1  one-cycle cell write strobe.
- mark  output  1  value written with wr_en (= current player).
- player  output  1  player whose turn it is.
- move_count  output  4  moves accepted this game, 0..9.
- reject  output  1  one-cycle pulse: confirm on an occupied cell.
- clear_board  output  1  one-cycle pulse: cell registers clear.
- game_done  output  1  high while in DONE.

Behaviour:
- Single clock domain: one clock (clk); reset is synchronous and active-high (rst). All state updates on the rising edge of clk.
- Reset values: cursor=0, sel=0, player=START_PLAYER, mark=START_PLAYER, move_count=0, wr_en=0, reject=0, clear_board=0, game_done=0, state=SELECT.
- Outputs are registered (Moore) or direct functions of state and registers; no input-to-output combinational path.
- `sel` shows the cursor in SELECT; in CHECK, WRITE and REJECT it holds the latched target.
- States: SELECT, CHECK, WRITE, REJECT, SWITCH, DONE.
- SELECT:
  - btn_confirm has priority over next/prev. It latches target=cursor and goes to CHECK; the cursor is unchanged.
  - btn_next alone: cursor+1, wrapping 8->0.
  - btn_prev alone: cursor-1, wrapping 0->8.
  - btn_next and btn_prev together: no change.
- CHECK (1 cycle):
  - occ[target]=1 -> REJECT.
  - occ[target]=0 -> WRITE.
- REJECT (1 cycle): reject=1, then SELECT. Player and move_count are unchanged.
- WRITE (1 cycle): wr_en=1, sel=target, mark=player, then SWITCH.
- SWITCH (1 cycle):
  - Always: move_count+1, player toggles.
  - If win=1 or the new move_count=9 -> DONE; otherwise SELECT.
  - win is sampled only in SWITCH.
- Latency: confirm in cycle t gives CHECK at t+1, wr_en at t+2, SWITCH at t+3, and SELECT (or DONE) at t+4. A rejected confirm returns to SELECT at t+3.
- Buttons are ignored outside SELECT; pulses arriving in CHECK, WRITE, REJECT, SWITCH or DONE are dropped, not queued.
- DONE:
  - game_done=1; all buttons are ignored.
  - move_count and player hold. player is the side that would move next; the winner is ~player.
- new_game (any state):
  - Next cycle: state=SELECT, cursor=0, player=START_PLAYER, move_count=0.
  - clear_board=1 for exactly one cycle.
  - It overrides any in-progress transition; a pending wr_en is cancelled.
- rst has priority over new_game. rst mid-write suppresses wr_en in the following cycle.
- move_count never exceeds 9. With NUM_CELLS=9 and SEL_W=9, sel[8:4]=0 always.

Test Plan:
- Reset, then 3x btn_next, then btn_confirm with occ=0 -> sel=3, wr_en=1 with mark=0 exactly 2 cycles after the confirm; then player=1, move_count=1.
- From cursor=0, btn_prev -> sel=8; then btn_next -> sel=0. Simultaneous next+prev -> sel unchanged.
- Confirm at cursor=4 with occ=9'b000010000 -> reject=1 for one cycle; no wr_en; player and move_count unchanged; back in SELECT.
- win=1 driven during the SWITCH after the 5th move -> game_done=1 and move_count=5. Later btn_confirm/btn_next produce no sel change and no wr_en.
- Nine valid moves with win=0 -> DONE after the 9th SWITCH with move_count=9. A new_game pulse then gives clear_board=1 for one cycle, move_count=0, player=0, sel=0.
- rst asserted in the WRITE cycle -> all outputs at reset values on the next cycle. new_game in CHECK -> no wr_en follows.
